// File: rtl/inst_queue_if.sv
// Fetch/decode-facing signals of the instruction queue.
// Handshake: an entry moves into the queue at a posedge where enq_valid && !full,
// and leaves it at a posedge where deq_ready && valid_inst; neither side waits on the other combinationally.
interface inst_queue_if #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
);
    logic             enq_valid;
    logic [31:0]      enq_pc;
    logic [31:0]      enq_inst;
    logic             enq_branch_pred;
    logic             full;
    logic             deq_ready;
    logic             valid_inst;
    logic [63:0]      queue_packet;
    logic             branch_pred;
    logic             empty;
    logic [CNT_W-1:0] count;

    modport master (
        output enq_valid, enq_pc, enq_inst, enq_branch_pred, deq_ready,
        input  full, valid_inst, queue_packet, branch_pred, empty, count
    );

    modport slave (
        input  enq_valid, enq_pc, enq_inst, enq_branch_pred, deq_ready,
        output full, valid_inst, queue_packet, branch_pred, empty, count
    );
endinterface

// File: rtl/inst_queue.sv
// In-order instruction queue between fetch and decode with first-word fall-through
// and single-cycle flush on branch mispredict.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         branch_mispredict,
    inst_queue_if.slave  q
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      inst_mem [DEPTH];
    logic             pred_mem [DEPTH];
    logic [PTR_W-1:0] head_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [CNT_W-1:0] count_r;
    logic             full_w;
    logic             empty_w;
    logic             enq_fire;
    logic             deq_fire;
    logic             flush;

    // Full/empty come only from the registered count, so a dequeue never frees a slot in the same cycle.
    assign full_w   = (count_r == CNT_W'(DEPTH));
    assign empty_w  = (count_r == '0);
    assign flush    = rst || branch_mispredict;
    assign enq_fire = q.enq_valid && !full_w;
    assign deq_fire = q.deq_ready && !empty_w;

    always_ff @(posedge clk) begin
        if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count_r  <= '0;
        end else begin
            if (enq_fire) tail_ptr <= tail_ptr + PTR_W'(1);
            if (deq_fire) head_ptr <= head_ptr + PTR_W'(1);
            case ({enq_fire, deq_fire})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is never cleared; a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (enq_fire && !flush) begin
            pc_mem[tail_ptr]   <= q.enq_pc;
            inst_mem[tail_ptr] <= q.enq_inst;
            pred_mem[tail_ptr] <= q.enq_branch_pred;
        end
    end

    always_comb begin
        q.queue_packet = 64'h0;
        q.branch_pred  = 1'b0;
        if (!empty_w) begin
            q.queue_packet = {pc_mem[head_ptr], inst_mem[head_ptr]};
            q.branch_pred  = pred_mem[head_ptr];
        end
    end

    assign q.full       = full_w;
    assign q.empty      = empty_w;
    assign q.valid_inst = !empty_w;
    assign q.count      = count_r;
endmodule
